// File: rtl/mem_access_arbiter_pkg.sv
// Shared definitions for the memory access arbiter.
// Holds the FSM state encoding, the access size codes, the R_W polarity
// constants and a helper that sizes the optional MOC wait counter.
package mem_access_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ACCESS  = 2'b01,
    ST_RELEASE = 2'b10
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Width of a counter able to hold max_count, never narrower than 8 bits.
  function automatic int cnt_width(input int max_count);
    int w;
    w = $clog2(max_count + 1);
    return (w > 8) ? w : 8;
  endfunction

endpackage

// File: rtl/mem_access_arbiter_rr_arbiter2.sv
// rr_arbiter2: combinational winner select between two requesters.
// Ports:
//   i_req0, i_req1 : request lines
//   i_last         : requester served by the most recent completed transaction
//   o_any          : at least one request is pending
//   o_sel          : winner (0 = requester 0, 1 = requester 1)
// FIXED_PRI = 1 makes requester 0 win every tie; otherwise a tie goes to
// the requester that was not served last.
module rr_arbiter2 #(
  parameter int FIXED_PRI = 0
) (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_any,
  output logic o_sel
);

  logic w_tie;

  assign w_tie = i_req0 & i_req1;
  assign o_any = i_req0 | i_req1;

  always_comb begin
    o_sel = i_req1;
    if (w_tie) begin
      o_sel = (FIXED_PRI != 0) ? 1'b0 : ~i_last;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: two-requester arbiter and MOV/MOC sequencer for the
// single RAM port behind the MAR/MDR path.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no owner; arbitrate and latch the winner's transaction
// ACCESS  | mem_MOV high, mem_* registers frozen, waiting for mem_MOC
// RELEASE | done issued, waiting for mem_MOC to fall before freeing gnt
// (2'b11 is illegal and falls back to IDLE on the next edge)
//
// Ports:
//   clk, clr (sync, active-low)        clock and reset
//   req/rw/addr/size/wdata 0 and 1     requester transactions
//   gnt0/gnt1, done0/done1, err, rdata responses to the requesters
//   mem_MOV/R_W/addr/size/wdata        registered memory command
//   mem_rdata, mem_MOC                 memory response
//
// Build option MEM_ARB_TIMEOUT_EN: bounds the mem_MOC wait to TIMEOUT_CYC
// cycles and reports err=1 with done on expiry. Without it err is tied 0.
module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int FIXED_PRI   = 0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req0,
  input  logic              req1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [1:0]        size0,
  input  logic [1:0]        size1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_MOV,
  output logic              mem_R_W,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_size,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_MOC
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_done0;
  logic              r_done1;
  logic [DATA_W-1:0] r_rdata;
  logic              r_mov;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic [DATA_W-1:0] r_wdata;

  logic w_any;
  logic w_sel;
  logic w_load;
  logic w_finish;
  logic w_free;
  logic w_timeout;

  rr_arbiter2 #(
    .FIXED_PRI (FIXED_PRI)
  ) u_arb (
    .i_req0 (req0),
    .i_req1 (req1),
    .i_last (r_last),
    .o_any  (w_any),
    .o_sel  (w_sel)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = cnt_width(TIMEOUT_CYC);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // The edge that would bring the count to TIMEOUT_CYC ends the wait, so
  // done lands exactly TIMEOUT_CYC cycles after mem_MOV rose.
  assign w_timeout = (r_state == ST_ACCESS) && !mem_MOC &&
                     (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_finish & w_timeout;
      if (r_state != ST_ACCESS) begin
        r_cnt <= '0;
      end else if (!mem_MOC) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  // Constant 0: ACCESS waits for mem_MOC indefinitely.
  assign w_timeout = (TIMEOUT_CYC < 0);
  assign err       = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_finish    = 1'b0;
    w_free      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_load      = 1'b1;
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem_MOC || w_timeout) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!mem_MOC) begin
          w_free      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_free      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_rdata <= '0;
      r_mov   <= 1'b0;
      r_rw    <= 1'b0;
      r_addr  <= '0;
      r_size  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      if (w_load) begin
        r_mov   <= 1'b1;
        r_gnt0  <= ~w_sel;
        r_gnt1  <= w_sel;
        r_rw    <= w_sel ? rw1    : rw0;
        r_addr  <= w_sel ? addr1  : addr0;
        r_size  <= w_sel ? size1  : size0;
        r_wdata <= w_sel ? wdata1 : wdata0;
      end
      if (w_finish) begin
        r_mov   <= 1'b0;
        r_done0 <= r_gnt0;
        r_done1 <= r_gnt1;
        // gnt is one-hot here, so gnt1 names the requester just served
        r_last  <= r_gnt1;
        if (mem_MOC && (r_rw == RW_READ)) begin
          r_rdata <= mem_rdata;
        end
      end
      if (w_free) begin
        r_mov  <= 1'b0;
        r_gnt0 <= 1'b0;
        r_gnt1 <= 1'b0;
      end
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign done0     = r_done0;
  assign done1     = r_done1;
  assign rdata     = r_rdata;
  assign mem_MOV   = r_mov;
  assign mem_R_W   = r_rw;
  assign mem_addr  = r_addr;
  assign mem_size  = r_size;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_access_arbiter.sv
module tb_mem_access_arbiter;
  import mem_access_arbiter_pkg::*;

  localparam int TB_FIXED_PRI = 0;
  localparam int TB_TIMEOUT   = 16;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        req   [2];
  logic        rw    [2];
  logic [31:0] addr  [2];
  logic [1:0]  size  [2];
  logic [31:0] wdata [2];
  logic        gnt0, gnt1, done0, done1, err;
  logic [31:0] rdata;
  logic        mem_MOV, mem_R_W;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic [31:0] mem_rdata;
  logic        mem_MOC;

  mem_access_arbiter #(
    .ADDR_W(32), .DATA_W(32), .FIXED_PRI(TB_FIXED_PRI), .TIMEOUT_CYC(TB_TIMEOUT)
  ) dut (
    .clk(clk), .clr(clr),
    .req0(req[0]), .req1(req[1]), .rw0(rw[0]), .rw1(rw[1]),
    .addr0(addr[0]), .addr1(addr[1]), .size0(size[0]), .size1(size[1]),
    .wdata0(wdata[0]), .wdata1(wdata[1]),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
    .rdata(rdata), .mem_MOV(mem_MOV), .mem_R_W(mem_R_W), .mem_addr(mem_addr),
    .mem_size(mem_size), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_MOC(mem_MOC)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  int          resp_len   = 0;     // cycles mem_MOV stays high; 0 = random 1..5
  bit          resp_en    = 1'b1;  // 0 = never answer
  bit          resp_fixed = 1'b0;
  logic [31:0] resp_fixed_data = '0;
  logic [31:0] resp_last_data  = '0;
  int          resp_cnt  = 0;
  int          resp_tgt  = 1;
  int          resp_drop = 0;

  initial begin
    mem_MOC   = 1'b0;
    mem_rdata = '0;
  end

  always @(posedge clk) begin
    #1;
    if (!mem_MOC) begin
      if (mem_MOV && resp_en) begin
        if (resp_cnt == 0) resp_tgt = (resp_len > 0) ? resp_len : int'($urandom_range(1, 5));
        resp_cnt++;
        if (resp_cnt >= resp_tgt) begin
          resp_last_data = resp_fixed ? resp_fixed_data : $urandom;
          mem_rdata      = resp_last_data;
          mem_MOC        = 1'b1;
          resp_cnt       = 0;
          resp_drop      = int'($urandom_range(0, 2));
        end
      end else if (!mem_MOV) begin
        resp_cnt = 0;
      end
    end else if (!mem_MOV) begin
      if (resp_drop == 0) begin
        mem_MOC   = 1'b0;
        mem_rdata = $urandom;
      end else begin
        resp_drop--;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    int          id;
    logic        rw;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          gnt_log[$];
  exp_t        mon_e;
  bit          expect_timeout = 1'b0;
  logic        req_s   [2];
  logic        rw_s    [2];
  logic [31:0] addr_s  [2];
  logic [1:0]  size_s  [2];
  logic [31:0] wdata_s [2];
  logic        clr_s      = 1'b0;
  logic        prev_mov   = 1'b0;
  logic        prev_done0 = 1'b0;
  logic        prev_done1 = 1'b0;
  logic        prev_gnt   = 1'b0;
  logic        prev_moc   = 1'b0;
  int          last_m = 1;       // requester served last
  logic [31:0] rd_m   = '0;      // value rdata must hold
  int          mov_len = 0;
  int          last_mov_len = 0;

  always @(negedge clk) begin
    if (!clr_s) begin
      chk("reset_ctrl", {gnt0, gnt1, done0, done1, err, mem_MOV, mem_R_W, mem_size}, '0);
      chk("reset_rdata", rdata, '0);
      chk("reset_mem_addr_wdata", {mem_addr, mem_wdata}, '0);
      exp_q.delete();
      last_m  = 1;
      rd_m    = '0;
      mov_len = 0;
    end else begin
      chk("gnt_exclusive", gnt0 & gnt1, 0);
      if (mem_MOV && !prev_mov) begin
        mon_e.id = -1;
        if (req_s[0] && req_s[1])
          mon_e.id = (TB_FIXED_PRI != 0) ? 0 : ((last_m == 0) ? 1 : 0);
        else if (req_s[0]) mon_e.id = 0;
        else if (req_s[1]) mon_e.id = 1;
        chk("grant_has_request", (mon_e.id >= 0), 1);
        if (mon_e.id >= 0) begin
          mon_e.rw    = rw_s[mon_e.id];
          mon_e.addr  = addr_s[mon_e.id];
          mon_e.size  = size_s[mon_e.id];
          mon_e.wdata = wdata_s[mon_e.id];
          mon_e.err   = expect_timeout;
          exp_q.push_back(mon_e);
          gnt_log.push_back(mon_e.id);
          chk("grant_id", {gnt0, gnt1}, (mon_e.id == 0) ? 2'b10 : 2'b01);
          chk("grant_mem_fields", {mem_R_W, mem_size, mem_addr, mem_wdata},
              {mon_e.rw, mon_e.size, mon_e.addr, mon_e.wdata});
        end
        mov_len = 1;
      end else if (mem_MOV) begin
        mov_len++;
        if (exp_q.size() > 0) begin
          chk("access_stable", {gnt0, gnt1, mem_R_W, mem_size, mem_addr, mem_wdata},
              {(exp_q[0].id == 0) ? 2'b10 : 2'b01, exp_q[0].rw, exp_q[0].size,
               exp_q[0].addr, exp_q[0].wdata});
        end
      end
      if (!mem_MOV && prev_mov) last_mov_len = mov_len;
      if (done0 || done1) begin
        chk("done_single", done0 & done1, 0);
        chk("done_with_mov_fall", {prev_mov, mem_MOV}, 2'b10);
        chk("done_expected", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("done_id", {done0, done1}, (mon_e.id == 0) ? 2'b10 : 2'b01);
          chk("done_err", err, mon_e.err);
          if (mon_e.rw == RW_READ && !mon_e.err) rd_m = resp_last_data;
          last_m = mon_e.id;
        end
      end
      chk("done_pulse_width", (done0 && prev_done0) || (done1 && prev_done1), 0);
      chk("rdata", rdata, rd_m);
      if (prev_gnt && !(gnt0 || gnt1)) chk("gnt_free_after_moc_low", prev_moc, 0);
    end
    prev_mov   = mem_MOV;
    prev_done0 = done0;
    prev_done1 = done1;
    prev_gnt   = gnt0 | gnt1;
    prev_moc   = mem_MOC;
    req_s      = req;
    rw_s       = rw;
    addr_s     = addr;
    size_s     = size;
    wdata_s    = wdata;
    clr_s      = clr;
  end

  // ---------------- stimulus ----------------
  task automatic do_txn(input int id, input logic r, input logic [31:0] a,
                        input logic [1:0] s, input logic [31:0] w);
    int n;
    bit seen;
    rw[id] = r; addr[id] = a; size[id] = s; wdata[id] = w; req[id] = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(posedge clk); #1;
      n++;
      seen = (id == 0) ? done0 : done1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL txn_done_wait id=%0d actual=no_done required=done_within_400", id);
    end
    req[id] = 1'b0;
  endtask

  task automatic rand_txn(input int id);
    logic [1:0] s;
    s = 2'($urandom_range(0, 2));
    do_txn(id, 1'($urandom), $urandom, s, $urandom);
  endtask

  task automatic settle_monitor();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; rw[i] = 1'b0; addr[i] = '0; size[i] = '0; wdata[i] = '0;
    end
    // reset held 2 cycles with req0 already asking for a read
    rw[0] = RW_READ; addr[0] = 32'h0000_0010; size[0] = SZ_WORD; req[0] = 1'b1;
    clr = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    clr = 1'b1;
    resp_fixed = 1'b1; resp_fixed_data = 32'hDEADBEEF; resp_len = 2;
    do_txn(0, RW_READ, 32'h0000_0010, SZ_WORD, 32'h0);
    settle_monitor();
    chk("first_read_rdata", rdata, 32'hDEADBEEF);
    chk("first_read_size", mem_size, SZ_WORD);
    chk("first_read_mov_len", last_mov_len, 2);
    resp_fixed = 1'b0;

    // slow write
    resp_len = 10;
    do_txn(1, RW_WRITE, 32'h0000_0100, SZ_WORD, 32'h1234_5678);
    settle_monitor();
    chk("slow_write_mov_len", last_mov_len, 10);
    chk("slow_write_rdata_kept", rdata, 32'hDEADBEEF);

    // simultaneous continuous requests
    resp_len = 0;
    start = gnt_log.size();
    fork
      begin repeat (3) rand_txn(0); end
      begin repeat (3) rand_txn(1); end
    join
    settle_monitor();
    chk("tie_grant_count", gnt_log.size() - start, 6);
    for (int i = 0; i < 6; i++) begin
      if (start + i < gnt_log.size())
        chk("tie_grant_order", gnt_log[start + i],
            (TB_FIXED_PRI != 0) ? ((i < 3) ? 0 : 1) : (i % 2));
    end

    // reset in the middle of ACCESS
    resp_len = 50;
    rw[0] = RW_READ; addr[0] = 32'h0000_0040; size[0] = SZ_HALF; req[0] = 1'b1;
    start = 0;
    while (!mem_MOV && start < 20) begin @(posedge clk); #1; start++; end
    chk("midreset_mov_seen", mem_MOV, 1);
    repeat (2) begin @(posedge clk); #1; end
    clr = 1'b0; req[0] = 1'b0;
    @(posedge clk); #1;
    chk("midreset_outputs", {mem_MOV, done0, gnt0}, 3'b000);
    clr = 1'b1;
    resp_len = 2;
    do_txn(0, RW_READ, 32'h0000_0044, SZ_BYTE, 32'h0);

    // randomized traffic on both ports
    resp_len = 0;
    fork
      begin
        repeat (25) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          rand_txn(0);
        end
      end
      begin
        repeat (25) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          rand_txn(1);
        end
      end
    join

`ifdef MEM_ARB_TIMEOUT_EN
    resp_en = 1'b0; expect_timeout = 1'b1;
    do_txn(0, RW_READ, 32'h0000_0200, SZ_WORD, 32'h0);
    settle_monitor();
    chk("timeout_mov_len", last_mov_len, TB_TIMEOUT);
    resp_en = 1'b1; expect_timeout = 1'b0;
    resp_len = 1;
    do_txn(1, RW_READ, 32'h0000_0204, SZ_WORD, 32'h0);
`endif

    repeat (5) begin @(posedge clk); #1; end
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
